// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared BCD segment definitions and converter state encodings.
// Also used by the binary-to-BCD display path.
package bcd_to_binary_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_mac10.sv
// One Horner step: acc*10 + digit, flagging a non-BCD digit.
// Built from shifts so no multiplier is needed.
module bcd_mac10
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [OUT_W-1:0]       acc_o,
  output logic                   digit_bad_o
);

  always_comb begin
    acc_o = (acc_i << 3) + (acc_i << 1) + OUT_W'(digit_i);
    digit_bad_o = digit_i > BCD_MAX_DIGIT;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Digit-serial BCD to binary converter, most significant digit first.
// Result and error flag are registered and held between conversions.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BCD_DIGIT_W-1:0] bcd_3,
  input  logic [BCD_DIGIT_W-1:0] bcd_2,
  input  logic [BCD_DIGIT_W-1:0] bcd_1,
  input  logic [BCD_DIGIT_W-1:0] bcd_0,
  output logic                   busy,
  output logic                   done,
  output logic [OUT_W-1:0]       binary,
  output logic                   err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic errint_q, errint_d;
  logic [BCD_DIGIT_W-1:0] dig_q [DIGITS];
  logic [BCD_DIGIT_W-1:0] dig_d [DIGITS];
  logic [OUT_W-1:0] bin_q, bin_d;
  logic err_q, err_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic [OUT_W-1:0] mac_acc;
  logic mac_bad;

  bcd_mac10 #(
    .OUT_W(OUT_W)
  ) u_mac (
    .acc_i      (acc_q),
    .digit_i    (dig_q[cnt_q]),
    .acc_o      (mac_acc),
    .digit_bad_o(mac_bad)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    errint_d = errint_q;
    dig_d    = dig_q;
    bin_d    = bin_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dig_d[0] = bcd_0;
          dig_d[1] = bcd_1;
          dig_d[2] = bcd_2;
          dig_d[3] = bcd_3;
          acc_d    = '0;
          cnt_d    = CW'(DIGITS - 1);
          errint_d = 1'b0;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        // bad digits keep going; only the final result is squashed
        acc_d    = mac_acc;
        errint_d = errint_q | mac_bad;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        bin_d   = errint_q ? '0 : acc_q;
        err_d   = errint_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      errint_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      errint_q <= errint_d;
      dig_q    <= dig_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = bin_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq.
// Expected values are hand-computed decimal conversions.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] bcd_3 = 4'd0;
  logic [3:0] bcd_2 = 4'd0;
  logic [3:0] bcd_1 = 4'd0;
  logic [3:0] bcd_0 = 4'd0;
  logic busy, done, err;
  logic [15:0] binary;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_seq #(
    .DIGITS(4),
    .OUT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd_3 (bcd_3),
    .bcd_2 (bcd_2),
    .bcd_1 (bcd_1),
    .bcd_0 (bcd_0),
    .busy  (busy),
    .done  (done),
    .binary(binary),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bcd(input logic [3:0] d3, d2, d1, d0);
    bcd_3 = d3;
    bcd_2 = d2;
    bcd_1 = d1;
    bcd_0 = d0;
  endtask

  // wait for done, bounded; returns cycles waited
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic conv(input string tag, input logic [3:0] d3, d2, d1, d0,
                      input logic [15:0] exp_bin, input logic exp_err);
    int n;
    set_bcd(d3, d2, d1, d0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, n, 32'd5);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "_bin"}, {16'd0, binary}, {16'd0, exp_bin});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    tick();
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hold"}, {16'd0, binary}, {16'd0, exp_bin});
  endtask

  initial begin
    int n;
    int pulses;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bin", {16'd0, binary}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1 / T2
    conv("t1", 4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0);
    conv("t2a", 4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0);
    conv("t2b", 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);

    // T3: invalid digit, then recovery
    conv("t3a", 4'd1, 4'hA, 4'd3, 4'd4, 16'h0000, 1'b1);
    conv("t3b", 4'd0, 4'd0, 4'd4, 4'd2, 16'd42, 1'b0);
    conv("t3c", 4'd0, 4'd0, 4'd0, 4'hF, 16'h0000, 1'b1);

    // T4: inputs and start during busy are ignored
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    set_bcd(4'd9, 4'd8, 4'd7, 4'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("t4_lat", n, 32'd3);
    chk("t4_bin", {16'd0, binary}, 32'd1234);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
      chk("t4_stable", {16'd0, binary}, 32'd1234);
    end
    chk("t4_pulses", pulses, 32'd0);

    // T5: reset mid-conversion
    set_bcd(4'd1, 4'd1, 4'd1, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_bin", {16'd0, binary}, 32'd0);
    chk("t5_err", {31'd0, err}, 32'd0);
    pulses = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("t5_nopulse", pulses, 32'd0);
    conv("t5r", 4'd5, 4'd6, 4'd7, 4'd8, 16'h162E, 1'b0);

    // T6: start held high re-triggers every 6 cycles
    set_bcd(4'd0, 4'd1, 4'd0, 4'd0);
    start = 1'b1;
    tick();
    wait_done(n);
    chk("t6_first", n, 32'd5);
    chk("t6_bin0", {16'd0, binary}, 32'd100);
    for (int k = 0; k < 3; k++) begin
      tick();
      wait_done(n);
      chk("t6_period", n + 1, 32'd6);
      chk("t6_bin", {16'd0, binary}, 32'd100);
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_end_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
